// File: rtl/tt_sweep_checker.sv
// Sweep-and-check stage: walks every input vector of an N_IN-input gate, samples
// its output after SETTLE cycles and compares it against a latched truth table.
module tt_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        stim,
    input  logic                   resp,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   mismatch,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err,
    output logic                   first_err_vld
);

    localparam int                TW          = 1 << N_IN;
    localparam logic [N_IN-1:0]   IDX_LAST    = N_IN'(TW - 1);
    localparam logic [N_IN-1:0]   IDX_ONE     = N_IN'(1);
    localparam logic [N_IN:0]     ERR_ONE     = (N_IN + 1)'(1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0]        CNT_ONE     = 4'd1;

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("tt_sweep_checker: SETTLE must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_expected;
    logic [N_IN-1:0]     r_stim;
    logic [3:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [TW-1:0]       r_mismatch;
    logic [N_IN:0]       r_err_count;
    logic [N_IN-1:0]     r_first_err;
    logic                r_first_err_vld;
    logic                w_last;
    logic                w_miss;

    // r_stim doubles as the vector index, so the driven vector and the checked bit never diverge
    assign w_last = (r_stim == IDX_LAST);
    assign w_miss = resp ^ r_expected[r_stim];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_APPLY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sweep datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected      <= '0;
            r_stim          <= '0;
            r_cnt           <= 4'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_mismatch      <= '0;
            r_err_count     <= '0;
            r_first_err     <= '0;
            r_first_err_vld <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_expected      <= expected;
                        r_stim          <= '0;
                        r_cnt           <= SETTLE_LOAD;
                        r_busy          <= 1'b1;
                        r_pass          <= 1'b0;
                        r_mismatch      <= '0;
                        r_err_count     <= '0;
                        r_first_err     <= '0;
                        r_first_err_vld <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_SAMPLE: begin
                    if (w_miss) begin
                        r_mismatch[r_stim] <= 1'b1;
                        r_err_count        <= r_err_count + ERR_ONE;
                        if (!r_first_err_vld) begin
                            r_first_err     <= r_stim;
                            r_first_err_vld <= 1'b1;
                        end
                    end
                    // The last vector stays on stim until the next accepted start
                    if (!w_last) begin
                        r_stim <= r_stim + IDX_ONE;
                        r_cnt  <= SETTLE_LOAD;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_pass <= (r_err_count == '0);
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign stim          = r_stim;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign mismatch      = r_mismatch;
    assign err_count     = r_err_count;
    assign first_err     = r_first_err;
    assign first_err_vld = r_first_err_vld;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: drivers push hand-computed results at
// start, per-instance monitors pop and compare on every done pulse.
module tb_tt_sweep_checker;

    typedef struct {
        logic [15:0] mm;
        logic [4:0]  ec;
        logic [3:0]  fe;
        logic        fv;
        logic        ps;
        int          tag;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] expected_a, expected_b;
    logic [3:0]  stim_a, stim_b;
    logic        resp_a, resp_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] mismatch_a, mismatch_b;
    logic [4:0]  err_count_a, err_count_b;
    logic [3:0]  first_err_a, first_err_b;
    logic        fev_a, fev_b;

    logic [15:0] gate_tbl = 16'h41A2;
    logic [1:0]  mode_a = 2'd0;
    logic        mode_b = 1'b0;
    int          cyc = 0;
    int          tag_a = 0, tag_b = 0;
    int          k_a, v_a;
    int          ndone_a = 0, ndone_b = 0;
    int          n_chk = 0, n_err = 0;
    bit          chk_stim_a = 1'b0, chk_stim_b = 1'b0;
    exp_t        q_a[$], q_b[$];
    exp_t        it_a, it_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_sweep_checker #(.N_IN(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(expected_a), .stim(stim_a),
        .resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mismatch_a),
        .err_count(err_count_a), .first_err(first_err_a), .first_err_vld(fev_a)
    );

    tt_sweep_checker #(.N_IN(4), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(expected_b), .stim(stim_b),
        .resp(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mismatch_b),
        .err_count(err_count_b), .first_err(first_err_b), .first_err_vld(fev_b)
    );

    // Gate models; mode 3 gives the wrong answer in every cycle except the last of each vector
    always_comb begin
        k_a = cyc - tag_a;
        v_a = k_a / 3;
        case (mode_a)
            2'd0:    resp_a = gate_tbl[stim_a];
            2'd1:    resp_a = 1'b0;
            2'd2:    resp_a = 1'b1;
            default: resp_a = ((k_a % 3) == 2) ? gate_tbl[v_a[3:0]] : ~gate_tbl[v_a[3:0]];
        endcase
        resp_b = mode_b ? 1'b0 : gate_tbl[stim_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_res(input string who, input exp_t it, input logic ps, input logic [15:0] mm,
                           input logic [4:0] ec, input logic [3:0] fe, input logic fv, input int lat);
        chk({who, "_pass"}, 32'(ps), 32'(it.ps));
        chk({who, "_mismatch"}, 32'(mm), 32'(it.mm));
        chk({who, "_err_count"}, 32'(ec), 32'(it.ec));
        chk({who, "_first_err"}, 32'(fe), 32'(it.fe));
        chk({who, "_first_err_vld"}, 32'(fv), 32'(it.fv));
        chk({who, "_latency"}, 32'(lat), 32'(it.lat));
    endtask

    function automatic exp_t mk(input logic [15:0] mm, input logic [4:0] ec, input logic [3:0] fe,
                                input logic fv, input logic ps, input int lat);
        exp_t e;
        e.mm = mm; e.ec = ec; e.fe = fe; e.fv = fv; e.ps = ps; e.tag = 0; e.lat = lat;
        return e;
    endfunction

    // Monitor for the SETTLE=2 instance
    always @(negedge clk) begin
        if (chk_stim_a && !rst && (cyc - tag_a) >= 0 && (cyc - tag_a) < 48)
            chk("a_stim_seq", 32'(stim_a), 32'((cyc - tag_a) / 3));
        if (done_a) begin
            if (q_a.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL a_unexpected_done: got done=1 at cycle %0d, want no done", cyc);
            end else begin
                it_a = q_a.pop_front();
                cmp_res("a", it_a, pass_a, mismatch_a, err_count_a, first_err_a, fev_a, cyc - it_a.tag);
            end
            ndone_a++;
        end
    end

    // Monitor for the SETTLE=1 instance
    always @(negedge clk) begin
        if (chk_stim_b && !rst && (cyc - tag_b) >= 0 && (cyc - tag_b) < 32)
            chk("b_stim_seq", 32'(stim_b), 32'((cyc - tag_b) / 2));
        if (done_b) begin
            if (q_b.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL b_unexpected_done: got done=1 at cycle %0d, want no done", cyc);
            end else begin
                it_b = q_b.pop_front();
                cmp_res("b", it_b, pass_b, mismatch_b, err_count_b, first_err_b, fev_b, cyc - it_b.tag);
            end
            ndone_b++;
        end
    end

    task automatic go(input bit sel, input logic [15:0] ex, input logic [1:0] md, input exp_t it);
        @(negedge clk);
        if (sel) begin
            expected_b = ex; mode_b = md[0]; start_b = 1'b1;
        end else begin
            expected_a = ex; mode_a = md; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        it.tag = cyc;
        if (sel) begin
            tag_b = cyc; q_b.push_back(it);
        end else begin
            tag_a = cyc; q_a.push_back(it);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int n0);
        int k;
        k = 0;
        while ((sel ? ndone_b : ndone_a) == n0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk(sel ? "b_done_seen" : "a_done_seen", 32'(sel ? ndone_b : ndone_a), 32'(n0 + 1));
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input bit sel, input logic [15:0] ex, input logic [1:0] md, input exp_t it);
        int n0;
        n0 = sel ? ndone_b : ndone_a;
        go(sel, ex, md, it);
        wait_done(sel, n0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1);
    end

    initial begin
        exp_t perf_a, sa0_a, sa1_a, perf_b, sa0_b, it;
        int   n0, t0;
        perf_a = mk(16'h0000, 5'd0,  4'd0, 1'b0, 1'b1, 49);
        sa0_a  = mk(16'h41A2, 5'd5,  4'd1, 1'b1, 1'b0, 49);
        sa1_a  = mk(16'hBE5D, 5'd11, 4'd0, 1'b1, 1'b0, 49);
        perf_b = mk(16'h0000, 5'd0,  4'd0, 1'b0, 1'b1, 33);
        sa0_b  = mk(16'h41A2, 5'd5,  4'd1, 1'b1, 1'b0, 33);

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        expected_a = 16'h0000; expected_b = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_stim", 32'(stim_a), 32'h0);
        chk("rst_flags", 32'({busy_a, done_a, pass_a, fev_a}), 32'h0);
        chk("rst_mismatch", 32'(mismatch_a), 32'h0);
        chk("rst_err_first", 32'({err_count_a, first_err_a}), 32'h0);
        rst = 1'b0;

        run(1'b0, 16'h41A2, 2'd0, perf_a);
        run(1'b0, 16'h41A2, 2'd1, sa0_a);
        run(1'b0, 16'h41A2, 2'd2, sa1_a);
        chk("a_stim_hold_last", 32'(stim_a), 32'hF);

        // Sample-point and stim-sequence timing
        chk_stim_a = 1'b1;
        run(1'b0, 16'h41A2, 2'd3, perf_a);
        chk_stim_a = 1'b0;

        // Repeated start mid-sweep plus expected changing after acceptance
        n0 = ndone_a;
        go(1'b0, 16'h41A2, 2'd0, perf_a);
        expected_a = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
        end
        chk("a_busy_mid", 32'(busy_a), 32'h1);
        wait_done(1'b0, n0);
        repeat (10) @(negedge clk);
        chk("a_single_done", 32'(ndone_a), 32'(n0 + 1));

        // start held across the DONE->IDLE edge: ignored there, accepted on the next edge
        n0 = ndone_a;
        go(1'b0, 16'h41A2, 2'd0, perf_a);
        t0 = tag_a;
        while (cyc < t0 + 48) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        chk("a_coinc_done", 32'(done_a), 32'h1);
        chk("a_coinc_ignored", 32'(busy_a), 32'h0);
        @(posedge clk);
        #1;
        it = perf_a;
        it.tag = cyc;
        tag_a = cyc;
        q_a.push_back(it);
        @(negedge clk);
        start_a = 1'b0;
        chk("a_coinc_accepted", 32'(busy_a), 32'h1);
        wait_done(1'b0, n0 + 1);

        // Asynchronous reset at vector 7 of a stuck-at-0 sweep
        n0 = ndone_a;
        go(1'b0, 16'h41A2, 2'd1, sa0_a);
        while (cyc < tag_a + 22) @(negedge clk);
        chk("a_pre_rst_stim", 32'(stim_a), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("a_rst_stim", 32'(stim_a), 32'h0);
        chk("a_rst_flags", 32'({busy_a, done_a, pass_a, fev_a}), 32'h0);
        chk("a_rst_mismatch", 32'(mismatch_a), 32'h0);
        chk("a_rst_err_first", 32'({err_count_a, first_err_a}), 32'h0);
        q_a.delete();
        @(negedge clk) rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("a_rst_no_done", 32'(ndone_a), 32'(n0));
        run(1'b0, 16'h41A2, 2'd2, sa1_a);

        // SETTLE=1 instance: two cycles per vector, done 33 cycles after start
        chk_stim_b = 1'b1;
        run(1'b1, 16'h41A2, 2'd0, perf_b);
        chk_stim_b = 1'b0;
        run(1'b1, 16'h41A2, 2'd1, sa0_b);

        chk("a_queue_empty", 32'(q_a.size()), 32'h0);
        chk("b_queue_empty", 32'(q_b.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
